// File: rtl/rtc_time_writer.sv
// Writes a captured BCD time (sec, min, hour) plus a transfer command to an external RTC
// over a multiplexed address/data bus, one four-transaction sequence per start pulse.
module rtc_time_writer #(
  parameter int unsigned PULSE_CYC = 10,
  parameter int unsigned GAP_CYC   = 10,
  parameter logic [7:0]  SEC_ADDR  = 8'h21,
  parameter logic [7:0]  MIN_ADDR  = 8'h22,
  parameter logic [7:0]  HOUR_ADDR = 8'h23,
  parameter logic [7:0]  CMD_ADDR  = 8'hF1,
  parameter logic [7:0]  CMD_DATA  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] HC,
  input  logic [7:0] MC,
  input  logic [7:0] SC,
  input  logic       AmPm,
  input  logic       format,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ad_sel,
  output logic       ad_oe,
  output logic [7:0] ad_out
);

  localparam int unsigned CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, ADDR, AGAP, DATA, DGAP, DONE} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [7:0]    sec_q;
  logic [7:0]    min_q;
  logic [7:0]    hour_q;

  function automatic logic [7:0] addr_of(input logic [1:0] i);
    case (i)
      2'd0:    addr_of = SEC_ADDR;
      2'd1:    addr_of = MIN_ADDR;
      2'd2:    addr_of = HOUR_ADDR;
      default: addr_of = CMD_ADDR;
    endcase
  endfunction

  function automatic logic [7:0] data_of(input logic [1:0] i, input logic [7:0] s,
                                         input logic [7:0] m, input logic [7:0] h);
    case (i)
      2'd0:    data_of = s;
      2'd1:    data_of = m;
      2'd2:    data_of = h;
      default: data_of = CMD_DATA;
    endcase
  endfunction

  assign rd_n = 1'b1;

  // Sequencer: every output is registered and set on the edge that enters its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= 2'd0;
      cnt    <= '0;
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      hour_q <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      ad_sel <= 1'b0;
      ad_oe  <= 1'b0;
      ad_out <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sec_q  <= SC;
            min_q  <= MC;
            // 12 h RTC hour register carries the PM flag in bit 7
            hour_q <= format ? {AmPm, 2'b00, HC[4:0]} : HC;
            state  <= ADDR;
            idx    <= 2'd0;
            cnt    <= '0;
            busy   <= 1'b1;
            cs_n   <= 1'b0;
            wr_n   <= 1'b0;
            ad_sel <= 1'b0;
            ad_oe  <= 1'b1;
            ad_out <= SEC_ADDR;
          end
        end
        ADDR: begin
          if (cnt == PULSE_LAST) begin
            state <= AGAP;
            cnt   <= '0;
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        AGAP: begin
          if (cnt == GAP_LAST) begin
            state  <= DATA;
            cnt    <= '0;
            cs_n   <= 1'b0;
            wr_n   <= 1'b0;
            ad_sel <= 1'b1;
            ad_out <= data_of(idx, sec_q, min_q, hour_q);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == PULSE_LAST) begin
            state <= DGAP;
            cnt   <= '0;
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DGAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (idx == 2'd3) begin
              state  <= DONE;
              idx    <= 2'd0;
              busy   <= 1'b0;
              done   <= 1'b1;
              cs_n   <= 1'b1;
              wr_n   <= 1'b1;
              ad_sel <= 1'b0;
              ad_oe  <= 1'b0;
              ad_out <= 8'h00;
            end else begin
              state  <= ADDR;
              idx    <= idx + 2'd1;
              cs_n   <= 1'b0;
              wr_n   <= 1'b0;
              ad_sel <= 1'b0;
              ad_out <= addr_of(idx + 2'd1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          idx    <= 2'd0;
          cnt    <= '0;
          busy   <= 1'b0;
          done   <= 1'b0;
          cs_n   <= 1'b1;
          wr_n   <= 1'b1;
          ad_sel <= 1'b0;
          ad_oe  <= 1'b0;
          ad_out <= 8'h00;
        end
      endcase
    end
  end

endmodule
